// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit:
// FSM states, opcode/func fields, ALU encodings and the decoded control bundle.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_LUI  = 3'b101;

    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic       memtoReg;
        logic       extOp;
        logic [2:0] aluCtr;
        logic       isLoad;
        logic       isStore;
        logic       isBranch;
        logic       isJump;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/func to control bundle plus illegal flag.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl    = CTRL_NONE;
        o_illegal = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                o_ctrl.regDst = 1'b1;
                case (i_func)
                    FN_ADDU: o_ctrl.aluCtr = ALU_ADD;
                    FN_SUBU: o_ctrl.aluCtr = ALU_SUB;
                    FN_AND:  o_ctrl.aluCtr = ALU_AND;
                    FN_OR:   o_ctrl.aluCtr = ALU_OR;
                    FN_SLT:  o_ctrl.aluCtr = ALU_SLT;
                    default: begin
                        o_ctrl    = CTRL_NONE;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_ORI: begin
                o_ctrl.aluSrc = 1'b1;
                o_ctrl.aluCtr = ALU_OR;
            end
            OP_LUI: begin
                o_ctrl.aluSrc = 1'b1;
                o_ctrl.aluCtr = ALU_LUI;
            end
            OP_LW: begin
                o_ctrl.aluSrc   = 1'b1;
                o_ctrl.extOp    = 1'b1;
                o_ctrl.memtoReg = 1'b1;
                o_ctrl.isLoad   = 1'b1;
                o_ctrl.aluCtr   = ALU_ADD;
            end
            OP_SW: begin
                o_ctrl.aluSrc  = 1'b1;
                o_ctrl.extOp   = 1'b1;
                o_ctrl.isStore = 1'b1;
                o_ctrl.aluCtr  = ALU_ADD;
            end
            OP_BEQ: begin
                o_ctrl.isBranch = 1'b1;
                o_ctrl.aluCtr   = ALU_SUB;
            end
            OP_J:    o_ctrl.isJump = 1'b1;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory-ready handshake
// and cycle / retired-instruction counters.
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             Zero,
    input  logic             mem_rdy,
    output logic             PCWr,
    output logic             IRWr,
    output logic             Branch,
    output logic             Jump,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWr,
    output logic             MemWr,
    output logic             ExtOp,
    output logic [2:0]       ALUctr,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    ctrl_t            r_dec;
    logic             r_decIllegal;
    logic [CNT_W-1:0] r_cycleCnt;
    logic [CNT_W-1:0] r_instret;

    state_t w_next;
    ctrl_t  w_dec;
    logic   w_decIllegal;
    logic   w_pcWr, w_irWr, w_branch, w_jump, w_regWr, w_memWr, w_illegal;
    logic   w_static;
    logic   w_unusedZero;

    // Zero only steers the datapath's next-PC mux; the controller never looks at it.
    assign w_unusedZero = Zero;

    mc_decode u_decode (
        .i_op      (op),
        .i_func    (func),
        .o_ctrl    (w_dec),
        .o_illegal (w_decIllegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IF;
            r_dec        <= CTRL_NONE;
            r_decIllegal <= 1'b0;
            r_cycleCnt   <= '0;
            r_instret    <= '0;
        end else begin
            r_state    <= w_next;
            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
            if (r_state == ST_ID) begin
                r_dec        <= w_dec;
                r_decIllegal <= w_decIllegal;
            end
            if (w_pcWr && !w_illegal) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pcWr    = 1'b0;
        w_irWr    = 1'b0;
        w_branch  = 1'b0;
        w_jump    = 1'b0;
        w_regWr   = 1'b0;
        w_memWr   = 1'b0;
        w_illegal = 1'b0;
        w_static  = 1'b0;
        case (r_state)
            ST_IF: begin
                w_irWr = mem_rdy;
                if (mem_rdy) w_next = ST_ID;
            end
            ST_ID: w_next = ST_EX;
            ST_EX: begin
                w_static = 1'b1;
                if (r_decIllegal) begin
                    w_pcWr    = 1'b1;
                    w_illegal = 1'b1;
                    w_next    = ST_IF;
                end else if (r_dec.isBranch) begin
                    w_pcWr   = 1'b1;
                    w_branch = 1'b1;
                    w_next   = ST_IF;
                end else if (r_dec.isJump) begin
                    w_pcWr = 1'b1;
                    w_jump = 1'b1;
                    w_next = ST_IF;
                end else if (r_dec.isLoad || r_dec.isStore) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                w_static = 1'b1;
                if (r_dec.isStore) begin
                    w_memWr = mem_rdy;
                    w_pcWr  = mem_rdy;
                end
                if (mem_rdy) w_next = r_dec.isStore ? ST_IF : ST_WB;
            end
            ST_WB: begin
                w_static = 1'b1;
                w_regWr  = 1'b1;
                w_pcWr   = 1'b1;
                w_next   = ST_IF;
            end
            default: w_next = ST_IF;
        endcase
    end

    // Gating with rst makes every output drop the instant reset asserts, even IRWr in IF.
    assign PCWr      = rst & w_pcWr;
    assign IRWr      = rst & w_irWr;
    assign Branch    = rst & w_branch;
    assign Jump      = rst & w_jump;
    assign RegWr     = rst & w_regWr;
    assign MemWr     = rst & w_memWr;
    assign illegal   = rst & w_illegal;
    assign RegDst    = rst & w_static & r_dec.regDst;
    assign ALUSrc    = rst & w_static & r_dec.aluSrc;
    assign MemtoReg  = rst & w_static & r_dec.memtoReg;
    assign ExtOp     = rst & w_static & r_dec.extOp;
    assign ALUctr    = (rst && w_static) ? r_dec.aluCtr : ALU_ADD;
    assign state     = r_state;
    assign cycle_cnt = r_cycleCnt;
    assign instret   = r_instret;

endmodule
